// File: rtl/la_view_ctrl_if.sv
// Command handshake bundle between the sys_clk requester and la_view_ctrl.
//   cmd_req : request level (asynchronous to pclk)
//   cmd_op  : opcode, stable while cmd_req=1
//   cmd_arg : operand, stable while cmd_req=1
//   cmd_ack : acknowledge level, registered in the pclk domain
interface la_view_ctrl_if #(
    parameter int unsigned ADDR_W = 10
) ();
    logic              cmd_req;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_arg;
    logic              cmd_ack;

    modport master (output cmd_req, output cmd_op, output cmd_arg, input cmd_ack);
    modport slave  (input cmd_req, input cmd_op, input cmd_arg, output cmd_ack);
endinterface

// File: rtl/la_view_ctrl.sv
// Frame-synchronous view controller for the logic-analyser waveform display.
// Commands arrive through a 4-phase req/ack handshake and are applied only on
// a vertical-sync rising edge, so the displayed window never changes mid-frame.
//   pclk, rst_n  : pixel clock, synchronous active-low reset
//   cmd          : command handshake (slave side)
//   i_vs         : vertical sync, active-high
//   start_addr   : capture start address (quasi-static)
//   pre_num      : pre-trigger sample count (quasi-static)
//   o_zoom_lvl   : zoom level 0..MAX_ZOOM
//   o_interval   : pixels per sample = 1 << o_zoom_lvl
//   o_offset     : view offset in samples
//   o_trig_addr  : trigger marker address
//   o_base_addr  : first RAM address of the frame
//   o_busy       : FSM not idle (combinational from state)
module la_view_ctrl #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned MAX_ZOOM = 6
) (
    input  logic               pclk,
    input  logic               rst_n,
    la_view_ctrl_if.slave      cmd,
    input  logic               i_vs,
    input  logic [ADDR_W-1:0]  start_addr,
    input  logic [ADDR_W-1:0]  pre_num,
    output logic [2:0]         o_zoom_lvl,
    output logic [6:0]         o_interval,
    output logic [ADDR_W-1:0]  o_offset,
    output logic [ADDR_W-1:0]  o_trig_addr,
    output logic [ADDR_W-1:0]  o_base_addr,
    output logic               o_busy
);
    localparam logic [2:0] LVL_MAX        = 3'(MAX_ZOOM);
    localparam logic [2:0] OP_SHIFT_L     = 3'd1;
    localparam logic [2:0] OP_SHIFT_R     = 3'd2;
    localparam logic [2:0] OP_ZOOM_IN     = 3'd3;
    localparam logic [2:0] OP_ZOOM_OUT    = 3'd4;
    localparam logic [2:0] OP_RESET_VIEW  = 3'd5;
    localparam logic [2:0] OP_SET_OFFSET  = 3'd6;

    typedef enum logic [1:0] {IDLE, PEND, ACK, DONE} state_t;

    state_t            state;
    logic              req_s1, req_s;
    logic              vs_d, vs_rise_d;
    logic              vs_rise_c;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] arg_q;
    logic [2:0]        lvl_nxt_c;
    logic [ADDR_W-1:0] off_nxt_c;

    assign vs_rise_c = i_vs & ~vs_d;
    assign o_busy    = (state != IDLE);

    // New view state for the latched command; NOP and reserved opcodes keep it.
    always_comb begin
        lvl_nxt_c = o_zoom_lvl;
        off_nxt_c = o_offset;
        case (op_q)
            OP_SHIFT_L:    off_nxt_c = o_offset + arg_q;
            OP_SHIFT_R:    off_nxt_c = o_offset - arg_q;
            OP_ZOOM_IN:    if (o_zoom_lvl < LVL_MAX) lvl_nxt_c = o_zoom_lvl + 3'd1;
            OP_ZOOM_OUT:   if (o_zoom_lvl != 3'd0)   lvl_nxt_c = o_zoom_lvl - 3'd1;
            OP_RESET_VIEW: begin
                off_nxt_c = '0;
                lvl_nxt_c = 3'd0;
            end
            OP_SET_OFFSET: off_nxt_c = arg_q;
            default: ;
        endcase
    end

    // Synchroniser, frame-edge detect, handshake FSM and frame parameters.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_s1      <= 1'b0;
            req_s       <= 1'b0;
            vs_d        <= 1'b0;
            vs_rise_d   <= 1'b0;
            op_q        <= 3'd0;
            arg_q       <= '0;
            cmd.cmd_ack <= 1'b0;
            o_zoom_lvl  <= 3'd0;
            o_interval  <= 7'd1;
            o_offset    <= '0;
            o_trig_addr <= '0;
            o_base_addr <= '0;
        end else begin
            req_s1    <= cmd.cmd_req;
            req_s     <= req_s1;
            vs_d      <= i_vs;
            vs_rise_d <= vs_rise_c;

            case (state)
                IDLE: begin
                    if (req_s) begin
                        op_q  <= cmd.cmd_op;
                        arg_q <= cmd.cmd_arg;
                        state <= PEND;
                    end
                end
                PEND: begin
                    if (vs_rise_c) begin
                        o_offset    <= off_nxt_c;
                        o_zoom_lvl  <= lvl_nxt_c;
                        o_interval  <= 7'd1 << lvl_nxt_c;
                        cmd.cmd_ack <= 1'b1;
                        state       <= ACK;
                    end
                end
                ACK: begin
                    if (!req_s) begin
                        cmd.cmd_ack <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // One cycle after the frame edge the new offset/level are visible,
            // so the frame's base address uses them.
            if (vs_rise_d) begin
                o_trig_addr <= start_addr + pre_num;
                o_base_addr <= start_addr + pre_num - (pre_num >> o_zoom_lvl) + o_offset;
            end
        end
    end
endmodule

// File: tb/tb_la_view_ctrl.sv
module tb_la_view_ctrl;
    localparam int unsigned ADDR_W = 10;

    logic              pclk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_vs = 1'b0;
    logic [ADDR_W-1:0] start_addr = 10'd100;
    logic [ADDR_W-1:0] pre_num = 10'd200;
    logic [2:0]        o_zoom_lvl;
    logic [6:0]        o_interval;
    logic [ADDR_W-1:0] o_offset;
    logic [ADDR_W-1:0] o_trig_addr;
    logic [ADDR_W-1:0] o_base_addr;
    logic              o_busy;

    la_view_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    la_view_ctrl #(.ADDR_W(ADDR_W), .MAX_ZOOM(6)) dut (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .cmd         (bus),
        .i_vs        (i_vs),
        .start_addr  (start_addr),
        .pre_num     (pre_num),
        .o_zoom_lvl  (o_zoom_lvl),
        .o_interval  (o_interval),
        .o_offset    (o_offset),
        .o_trig_addr (o_trig_addr),
        .o_base_addr (o_base_addr),
        .o_busy      (o_busy)
    );

    always #5 pclk = ~pclk;

    int total = 0;
    int bad   = 0;
    int m_off = 0;
    int m_lvl = 0;

    typedef struct {
        int lvl;
        int off;
        int iv;
        int base;
        int trig;
    } exp_t;
    exp_t sb[$];

    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference model of the view registers.
    task automatic model_apply(input int op, input int arg);
        case (op)
            1: m_off = (m_off + arg) & 1023;
            2: m_off = (m_off - arg) & 1023;
            3: if (m_lvl < 6) m_lvl++;
            4: if (m_lvl > 0) m_lvl--;
            5: begin m_off = 0; m_lvl = 0; end
            6: m_off = arg & 1023;
            default: ;
        endcase
    endtask

    task automatic push_exp();
        exp_t e;
        int sa, pn;
        sa = int'(start_addr);
        pn = int'(pre_num);
        e.lvl  = m_lvl;
        e.off  = m_off;
        e.iv   = 1 << m_lvl;
        e.trig = (sa + pn) & 1023;
        e.base = (sa + pn - (pn >> m_lvl) + m_off) & 1023;
        sb.push_back(e);
    endtask

    task automatic check_sb(input string tag);
        exp_t e;
        chk({tag, ".sb_avail"}, (sb.size() > 0) ? 1 : 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, ".lvl"},  int'(o_zoom_lvl),  e.lvl);
            chk({tag, ".off"},  int'(o_offset),    e.off);
            chk({tag, ".iv"},   int'(o_interval),  e.iv);
            chk({tag, ".base"}, int'(o_base_addr), e.base);
            chk({tag, ".trig"}, int'(o_trig_addr), e.trig);
        end
    endtask

    task automatic wait_ack(input logic val, input int max, input string tag);
        int n = 0;
        while (bus.cmd_ack !== val && n < max) begin
            tick(1);
            n++;
        end
        chk(tag, int'(bus.cmd_ack), int'(val));
    endtask

    task automatic frame();
        i_vs = 1'b1;
        tick(3);
        i_vs = 1'b0;
        tick(2);
    endtask

    // FSM sits in PEND: deliver a frame edge, check the result, finish handshake.
    task automatic apply_and_finish(input string tag);
        i_vs = 1'b1;
        tick(1);
        chk({tag, ".ack_rise"}, int'(bus.cmd_ack), 1);
        tick(2);
        i_vs = 1'b0;
        tick(1);
        check_sb(tag);
        bus.cmd_req = 1'b0;
        wait_ack(1'b0, 3, {tag, ".ack_fall"});
        tick(2);
        chk({tag, ".idle"}, int'(o_busy), 0);
    endtask

    task automatic do_cmd(input string tag, input int op, input int arg);
        int prev_off;
        prev_off = m_off;
        model_apply(op, arg);
        push_exp();
        bus.cmd_op  = 3'(op);
        bus.cmd_arg = 10'(arg);
        bus.cmd_req = 1'b1;
        tick(4);
        chk({tag, ".pend_off"},  int'(o_offset), prev_off);
        chk({tag, ".pend_busy"}, int'(o_busy), 1);
        apply_and_finish(tag);
    endtask

    initial begin
        bus.cmd_req = 1'b0;
        bus.cmd_op  = 3'd0;
        bus.cmd_arg = '0;
        tick(3);
        chk("rst.ack",  int'(bus.cmd_ack),  0);
        chk("rst.lvl",  int'(o_zoom_lvl),   0);
        chk("rst.iv",   int'(o_interval),   1);
        chk("rst.off",  int'(o_offset),     0);
        chk("rst.trig", int'(o_trig_addr),  0);
        chk("rst.base", int'(o_base_addr),  0);
        chk("rst.busy", int'(o_busy),       0);
        rst_n = 1'b1;
        tick(2);

        // Idle frames: address outputs refresh with no command.
        frame();
        frame();
        push_exp();
        check_sb("idle");
        chk("idle.ack", int'(bus.cmd_ack), 0);

        for (int i = 0; i < 3; i++) do_cmd($sformatf("zin%0d", i), 3, 0);
        for (int i = 3; i < 7; i++) do_cmd($sformatf("zin%0d", i), 3, 0);

        do_cmd("shr5", 2, 5);
        do_cmd("shl10", 1, 10);
        do_cmd("op7", 7, 10'h3FF);

        // Request synchronised onto the frame-edge cycle: applies one frame late.
        bus.cmd_op  = 3'd6;
        bus.cmd_arg = 10'd77;
        bus.cmd_req = 1'b1;
        tick(2);
        i_vs = 1'b1;
        tick(3);
        i_vs = 1'b0;
        tick(2);
        chk("vsreq.off_hold", int'(o_offset), m_off);
        chk("vsreq.busy", int'(o_busy), 1);
        chk("vsreq.ack", int'(bus.cmd_ack), 0);
        model_apply(6, 77);
        push_exp();
        apply_and_finish("vsreq");

        // Reset while pending with request held: re-accepted after reset.
        bus.cmd_op  = 3'd6;
        bus.cmd_arg = 10'd123;
        bus.cmd_req = 1'b1;
        tick(4);
        chk("rstp.busy_pre", int'(o_busy), 1);
        rst_n = 1'b0;
        tick(2);
        chk("rstp.off",  int'(o_offset),    0);
        chk("rstp.lvl",  int'(o_zoom_lvl),  0);
        chk("rstp.iv",   int'(o_interval),  1);
        chk("rstp.trig", int'(o_trig_addr), 0);
        chk("rstp.base", int'(o_base_addr), 0);
        chk("rstp.ack",  int'(bus.cmd_ack), 0);
        chk("rstp.busy", int'(o_busy),      0);
        m_off = 0;
        m_lvl = 0;
        rst_n = 1'b1;
        tick(5);
        chk("rstp.reaccept", int'(o_busy), 1);
        model_apply(6, 123);
        push_exp();
        apply_and_finish("rstp");

        // Request withdrawn before ack: no abort, still applied at next frame.
        bus.cmd_op  = 3'd2;
        bus.cmd_arg = 10'd200;
        bus.cmd_req = 1'b1;
        tick(4);
        bus.cmd_req = 1'b0;
        tick(4);
        chk("early.hold_busy", int'(o_busy), 1);
        chk("early.hold_off", int'(o_offset), m_off);
        model_apply(2, 200);
        push_exp();
        apply_and_finish("early");

        do_cmd("zin_a", 3, 0);
        do_cmd("rview", 5, 0);
        do_cmd("zout0", 4, 0);
        do_cmd("nop", 0, 10'h155);

        chk("sb.empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/la_view_ctrl.md
Name: la_view_ctrl

Overview:
Frame-synchronous view controller for the logic-analyser waveform display. It takes view commands (shift, zoom, reset view, set offset) from the slow sys_clk domain through a 4-phase req/ack handshake. Each command is applied only at the start of a video frame, so the displayed window never changes mid-frame. It outputs the zoom interval, view offset, trigger marker address and RAM base read address used by the waveform renderer in the pclk domain.

Parameters:
ADDR_W, 10, capture RAM address width; all address arithmetic is modulo 2^ADDR_W.
MAX_ZOOM, 6, highest zoom level; interval = 1 << level, so the maximum interval is 64.

Ports:
pclk  in  1  pixel clock.
rst_n  in  1  reset, synchronous, active-low.
cmd_req  in  1  request level from sys_clk domain; asynchronous to pclk.
cmd_op  in  3  opcode; held stable by the requester while cmd_req=1.
cmd_arg  in  ADDR_W  operand; held stable by the requester while cmd_req=1.
cmd_ack  out  1  acknowledge level, registered.
i_vs  in  1  vertical sync, active-high, pclk domain.
start_addr  in  ADDR_W  capture start address; quasi-static.
pre_num  in  ADDR_W  pre-trigger sample count; quasi-static.
o_zoom_lvl  out  3  current zoom level, 0..MAX_ZOOM.
o_interval  out  7  pixels per sample = 1 << o_zoom_lvl.
o_offset  out  ADDR_W  view offset in samples.
o_trig_addr  out  ADDR_W  trigger marker address = start_addr + pre_num.
o_base_addr  out  ADDR_W  first RAM address of the frame.
o_busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: cmd_ack=0, o_zoom_lvl=0, o_interval=1, o_offset=0, o_trig_addr=0, o_base_addr=0, o_busy=0. FSM resets to IDLE; the synchroniser and edge flops reset to 0.
- cmd_req synchronisation: two pclk flops give req_s. The FSM acts on req_s only.
- Frame-start detection: vs_d <= i_vs; vs_rise = i_vs & ~vs_d.
- FSM states and transitions:
  - IDLE: on req_s=1, latch cmd_op and cmd_arg, go to PEND.
  - PEND: wait for vs_rise. On the vs_rise cycle, apply the command (new o_offset / o_zoom_lvl visible next cycle), then go to ACK.
  - ACK: cmd_ack=1. When req_s=0, go to DONE.
  - DONE: cmd_ack=0, then go to IDLE. A new request is accepted only from IDLE.
- Opcodes:
  - 0 NOP: no register change.
  - 1 SHIFT_L: offset += arg.
  - 2 SHIFT_R: offset -= arg.
  - 3 ZOOM_IN: level += 1, saturating at MAX_ZOOM.
  - 4 ZOOM_OUT: level -= 1, saturating at 0.
  - 5 RESET_VIEW: offset = 0, level = 0.
  - 6 SET_OFFSET: offset = arg.
  - 7: reserved; treated as NOP but still acknowledged.
- Offset arithmetic wraps modulo 2^ADDR_W; there is no clamping.
- o_interval is registered and always equals 1 << o_zoom_lvl.
- Frame parameter update: on the cycle after vs_rise (vs_rise delayed by one, same cycle the new offset/level are visible), register:
  - o_trig_addr = start_addr + pre_num.
  - o_base_addr = start_addr + pre_num - (pre_num >> o_zoom_lvl) + o_offset, using the just-updated offset and level.
  - Both are therefore valid 2 cycles after the vs_rise cycle and held constant until the next frame. No divider is used.
- Simultaneous events:
  - req_s rises on the vs_rise cycle: FSM only enters PEND, so the command applies at the next frame.
  - vs_rise in ACK or DONE: only the address outputs refresh.
- At most one command is applied per frame.
- Reset mid-operation: all state clears. If cmd_req is still high after reset, req_s rises again and the command is re-executed; the requester must tolerate this.
- o_busy is combinational from the state register (state != IDLE).

Test Plan:
- Reset, then 2 frames with no command, start_addr=100, pre_num=200: o_trig_addr=300; o_base_addr=100 (300-200+0); o_interval=1; cmd_ack=0.
- ZOOM_IN issued 3 times (full handshake each), pre_num=200, start_addr=100: after the third frame, o_zoom_lvl=3, o_interval=8, o_base_addr=275 (300-25). A 4th..7th ZOOM_IN leaves level at 6 and o_interval=64.
- SHIFT_R arg=5 from offset 0: o_offset=1019 (wrap). Then SHIFT_L arg=10 -> o_offset=5. Both changes are visible only after the vs_rise following the request.
- Raise cmd_req on exactly the vs_rise cycle: offset unchanged through that frame, applied at the next vs_rise. cmd_ack rises 1 cycle after the apply and falls within 3 cycles of cmd_req dropping.
- Opcode 7 with arg=0x3FF: registers unchanged, cmd_ack still asserted.
- Assert rst_n=0 while in PEND: all outputs return to reset values. With cmd_req held high, the command is re-accepted and applied at the next frame.
- Deassert cmd_req before ack: FSM holds in PEND (no abort), then passes through ACK and DONE within a few cycles of the next vs_rise.
